// File: rtl/ex30_pkg.sv
// ex30_pkg: shared constants for the ex30 lookup table.
//   DefaultAddrW / DefaultDataW : default address and data widths
//   RomDepth / RomIdxW / RomWordW : geometry of the stored table
//   RomInit                       : fixed table contents, word 0 first
//   rom_word()                    : table read helper
package ex30_pkg;

  localparam int unsigned DefaultAddrW = 3;
  localparam int unsigned DefaultDataW = 16;

  localparam int unsigned RomDepth = 8;
  localparam int unsigned RomIdxW  = 3;
  localparam int unsigned RomWordW = 16;

  localparam logic [RomWordW-1:0] RomInit [RomDepth] = '{
    16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
    16'h0F0F, 16'hF0F0, 16'hAAAA, 16'h5555
  };

  function automatic logic [RomWordW-1:0] rom_word(input logic [RomIdxW-1:0] idx);
    return RomInit[idx];
  endfunction

endpackage

// File: rtl/ex30_rom.sv
// ex30_rom: purely combinational address-to-word lookup.
//   addr_i : read address (unsigned)
//   data_o : table word, zero-extended to DATA_W; addresses past the
//            stored table read as zero
module ex30_rom
  import ex30_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  logic               in_range;
  logic [RomIdxW-1:0] idx;

  // Any set bit above the table index bits means the address is past the table.
  if (ADDR_W > RomIdxW) begin : g_wide_addr
    assign in_range = (addr_i[ADDR_W-1:RomIdxW] == '0);
    assign idx      = addr_i[RomIdxW-1:0];
  end else begin : g_narrow_addr
    assign in_range = 1'b1;
    assign idx      = RomIdxW'(addr_i);
  end

  always_comb begin
    data_o = '0;
    if (in_range) begin
      data_o = DATA_W'(rom_word(idx));
    end
  end

endmodule

// File: rtl/ex30_top.sv
// ex30_top: registered single-port read-only lookup table, 1-cycle latency.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; clears spo immediately
//   addr  : read address, sampled every rising edge
//   spo   : registered read data
module ex30_top
  import ex30_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] spo
);

  logic [DATA_W-1:0] spo_d;
  logic [DATA_W-1:0] spo_q;

  ex30_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .addr_i (addr),
    .data_o (spo_d)
  );

  // Reset drops any read in flight; nothing is replayed afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spo_q <= '0;
    end else begin
      spo_q <= spo_d;
    end
  end

  assign spo = spo_q;

endmodule

// File: tb/tb_ex30_top.sv
`timescale 1ns/1ps
module tb_ex30_top;

  logic        clk;
  logic        rst_n;
  logic [2:0]  addr;
  logic [15:0] spo;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  ex30_top dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .spo   (spo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference contents, written independently of the design package.
  function automatic logic [15:0] ref_word(input int unsigned a);
    case (a)
      0: return 16'h1234;
      1: return 16'h5678;
      2: return 16'h9ABC;
      3: return 16'hDEF0;
      4: return 16'h0F0F;
      5: return 16'hF0F0;
      6: return 16'hAAAA;
      7: return 16'h5555;
      default: return 16'h0000;
    endcase
  endfunction

  // Behavioural model: reset clears output at once, otherwise each edge
  // delivers the word for the address seen at that edge.
  logic [15:0] model_spo;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_spo <= 16'h0000;
    else        model_spo <= ref_word(int'(addr));
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) check("model", spo, model_spo);
  end

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] seq [8];
    seq = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
            16'h0F0F, 16'hF0F0, 16'hAAAA, 16'h5555};

    rst_n = 1'b0;
    addr  = 3'd5;
    #1;
    check("reset_initial", spo, 16'h0000);
    cmp_en = 1'b1;
    repeat (3) edge_then_settle();
    check("reset_held", spo, 16'h0000);

    // Release between edges, first edge loads word 5.
    #2 rst_n = 1'b1;
    edge_then_settle();
    check("first_after_reset", spo, 16'hF0F0);

    // Sweep 0..7 then wrap to 0.
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      edge_then_settle();
      check("sweep", spo, seq[i]);
    end
    addr = addr + 3'd1;
    edge_then_settle();
    check("wrap", spo, 16'h1234);

    // Address change between edges must not leak through.
    addr = 3'd3;
    edge_then_settle();
    check("hold_pre", spo, 16'hDEF0);
    #2 addr = 3'd6;
    #1 check("hold_mid", spo, 16'hDEF0);
    edge_then_settle();
    check("hold_post", spo, 16'hAAAA);

    // Asynchronous reset pulse mid-cycle.
    addr = 3'd2;
    edge_then_settle();
    check("pre_pulse", spo, 16'h9ABC);
    #1 rst_n = 1'b0;
    #1 check("async_clear", spo, 16'h0000);
    #1 rst_n = 1'b1;
    addr = 3'd1;
    #1 check("after_release_no_edge", spo, 16'h0000);
    edge_then_settle();
    check("after_pulse", spo, 16'h5678);

    // Randomised traffic with occasional reset pulses; checked by the model.
    for (int i = 0; i < 300; i++) begin
      addr = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) begin
        #1 rst_n = 1'b0;
        #1 check("rand_async_clear", spo, 16'h0000);
        #1 rst_n = 1'b1;
      end
      edge_then_settle();
    end

    cmp_en = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex30_top.md
EX30_TOP -- requirements
Module: ex30_top

Interface
REQ-001 Parameter ADDR_W, default 3, SHALL set the address width (ROM depth = 2**ADDR_W words).
REQ-002 Parameter DATA_W, default 16, SHALL set the ROM word width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port addr, input, ADDR_W bits: read address, sampled every rising clk edge.
REQ-006 Port spo, output, DATA_W bits: registered single-port read data.

Function
REQ-007 The block SHALL be a read-only 8x16 lookup table with no write port and no enable; a read occurs every cycle.
REQ-008 ROM contents SHALL be fixed at elaboration: word0=0x1234, word1=0x5678, word2=0x9ABC, word3=0xDEF0, word4=0x0F0F, word5=0xF0F0, word6=0xAAAA, word7=0x5555.
REQ-009 On each rising clk edge with rst_n high, spo SHALL load ROM[addr] as sampled at that edge, giving 1-cycle read latency.
REQ-010 spo SHALL hold its value between edges and SHALL NOT change combinationally with addr.
REQ-011 addr SHALL be treated as unsigned; stepping addr from 7 to 0 (wrap-around) SHALL need no special handling, so the next edge returns word0.
REQ-012 Back-to-back different addresses on consecutive edges SHALL return each corresponding word on the following edge, at full throughput.
REQ-013 An X/Z addr SHALL NOT be a supported input; no behaviour is defined for it.
REQ-014 If DATA_W exceeds 16, each stored word SHALL be zero-extended; if ADDR_W exceeds 3, words at indices 8 and above SHALL read 0x0000.

Reset
REQ-015 rst_n low SHALL force spo to 0x0000 immediately, without waiting for a clk edge.
REQ-016 While rst_n is low, spo SHALL stay 0x0000 regardless of clk and addr.
REQ-017 After rst_n rises, the first rising clk edge SHALL load ROM[addr]; there are no other reset-dependent states.
REQ-018 Reset asserted mid-stream SHALL discard the pending read; no read is replayed after reset.

Structure
REQ-019 A shared package ex30_pkg SHALL hold ADDR_W/DATA_W defaults and the 8-entry ROM content constant array.
REQ-020 One sub-module, ex30_rom, SHALL implement the purely combinational address-to-word lookup; ex30_top SHALL hold only the output register and the reset logic.
REQ-021 The design SHALL contain no latches, and the only inferred flops SHALL be the DATA_W-bit spo register.

Verification
REQ-022 Hold rst_n low, toggle clk and set addr=5 -> spo stays 0x0000; release rst_n and apply one edge -> spo=0xF0F0.
REQ-023 Step addr 0..7, one address per clk edge -> spo returns 0x1234, 0x5678, 0x9ABC, 0xDEF0, 0x0F0F, 0xF0F0, 0xAAAA, 0x5555 in order, each one cycle after its address.
REQ-024 Increment addr past 7 so it wraps to 0 -> after 0x5555, spo returns 0x1234 on the next edge.
REQ-025 With spo=0xDEF0, change addr to 6 between edges -> spo stays 0xDEF0 until the next rising edge, then becomes 0xAAAA.
REQ-026 With spo=0x9ABC, pulse rst_n low between clock edges -> spo becomes 0x0000 asynchronously; after release, the first edge with addr=1 gives 0x5678.
